// File: rtl/execute_muldiv.sv
// Multi-cycle multiply/divide unit: MULT/MULTU/DIV/DIVU into HI/LO plus MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN to use a single-cycle combinational multiplier for MULT/MULTU.
module execute_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count;

    // Latched operand magnitudes and sign bookkeeping for the FIX step.
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic              neg_main;
    logic              neg_rem;
    logic              is_div;
    logic              by_zero;

    // Shared work registers: product {hi,lo} for MUL, {remainder,quotient} for DIV.
    logic [DATA_W-1:0] acc_hi;
    logic [DATA_W-1:0] acc_lo;

    logic              accept;
    logic              last_iter;
    logic              op_signed;
    logic              sign_a;
    logic              sign_b;
    logic [DATA_W-1:0] in_mag_a;
    logic [DATA_W-1:0] in_mag_b;
    logic              op_is_mul;
    logic              op_is_div;

    assign accept    = (state == S_IDLE) && start;
    assign last_iter = (count == LAST_ITER);
    assign op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign sign_a    = op_signed & src_a[DATA_W-1];
    assign sign_b    = op_signed & src_b[DATA_W-1];
    assign in_mag_a  = sign_a ? -src_a : src_a;
    assign in_mag_b  = sign_b ? -src_b : src_b;

    // Shift-add step: add multiplicand when the multiplier LSB is set, then shift right.
    logic [DATA_W:0]   mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : {(DATA_W+1){1'b0}});

    // Restoring divide step: shift in the next dividend bit and try to subtract.
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_trial;
    logic              div_fits;
    assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
    assign div_trial = div_shift - {1'b0, mag_b};
    assign div_fits  = ~div_trial[DATA_W];

    logic [2*DATA_W-1:0] mul_raw;
    logic [2*DATA_W-1:0] mul_res;
    logic [DATA_W-1:0]   fix_hi;
    logic [DATA_W-1:0]   fix_lo;

`ifdef MULDIV_FAST_MUL_EN
    assign mul_raw = {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
`else
    assign mul_raw = {acc_hi, acc_lo};
`endif
    assign mul_res = neg_main ? -mul_raw : mul_raw;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        fix_hi = mul_res[2*DATA_W-1:DATA_W];
        fix_lo = mul_res[DATA_W-1:0];
        if (is_div) begin
            if (by_zero) begin
                // Rebuilding the original dividend from its magnitude avoids a separate register.
                fix_hi = neg_rem ? -mag_a : mag_a;
                fix_lo = {DATA_W{1'b1}};
            end else begin
                fix_hi = neg_rem  ? -acc_hi : acc_hi;
                fix_lo = neg_main ? -acc_lo : acc_lo;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op_is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                        state_next = S_FIX;
`else
                        state_next = S_MUL;
`endif
                    end else if (op_is_div) begin
                        state_next = S_DIV;
                    end else if ((op == OP_MTHI) || (op == OP_MTLO)) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else if (last_iter) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = flush ? S_IDLE : S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == S_MUL) || (state_next == S_DIV) || (state_next == S_FIX);
            done  <= (state_next == S_DONE);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count    <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            is_div   <= 1'b0;
            by_zero  <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            div_zero <= (state == S_FIX) && !flush && is_div && by_zero;
            if (accept) begin
                count    <= '0;
                mag_a    <= in_mag_a;
                mag_b    <= in_mag_b;
                neg_main <= sign_a ^ sign_b;
                neg_rem  <= sign_a;
                is_div   <= op_is_div;
                by_zero  <= (src_b == '0);
                acc_hi   <= '0;
                acc_lo   <= op_is_div ? in_mag_a : in_mag_b;
                if (op == OP_MTHI) begin
                    hi <= src_a;
                end
                if (op == OP_MTLO) begin
                    lo <= src_a;
                end
            end else if ((state == S_MUL) && !flush) begin
                count  <= last_iter ? '0 : count + CNT_W'(1);
                acc_hi <= mul_sum[DATA_W:1];
                acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
            end else if ((state == S_DIV) && !flush) begin
                count  <= last_iter ? '0 : count + CNT_W'(1);
                acc_hi <= div_fits ? div_trial[DATA_W-1:0] : div_shift[DATA_W-1:0];
                acc_lo <= {acc_lo[DATA_W-2:0], div_fits};
            end else if ((state == S_FIX) && !flush) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end
    end

endmodule
